// File: rtl/fb_scanout_reader_pkg.sv
// rtl/fb_scanout_reader_pkg.sv - gpu_fb_pkg: framebuffer geometry, pixel layout and scanout FSM encoding
package gpu_fb_pkg;

  localparam int FB_WIDTH   = 640;
  localparam int FB_HEIGHT  = 400;
  localparam int FB_ADDR_W  = 18;
  localparam int FIFO_DEPTH = 8;
  localparam int PIX_W      = 16;

  // 12-bit RGB packed into the low bits of a 16-bit word
  localparam int PIX_R_MSB = 11;
  localparam int PIX_R_LSB = 8;
  localparam int PIX_G_MSB = 7;
  localparam int PIX_G_LSB = 4;
  localparam int PIX_B_MSB = 3;
  localparam int PIX_B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FETCH      = 2'd1,
    ST_LINE_DONE  = 2'd2,
    ST_FRAME_DONE = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_scanout_reader_if.sv
// rtl/fb_scanout_reader_if.sv - SRAM read port shared between the scanout reader and the SRAM
interface fb_scanout_reader_if;
  import gpu_fb_pkg::*;

  logic [FB_ADDR_W-1:0] oMEM_ADDR;
  logic                 oMEM_READ;
  logic                 oBUS_BUSY;
  logic [PIX_W-1:0]     iMEM_DATA;

  modport master (output oMEM_ADDR, output oMEM_READ, output oBUS_BUSY, input iMEM_DATA);
  modport slave  (input oMEM_ADDR, input oMEM_READ, input oBUS_BUSY, output iMEM_DATA);
endinterface

// File: rtl/fb_scanout_reader_fifo.sv
// rtl/fb_scanout_reader_fifo.sv - fb_pixel_fifo: synchronous pixel prefetch FIFO with flush and occupancy count
module fb_pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fb_scanout_reader.sv
// rtl/fb_scanout_reader.sv - framebuffer scanout reader: SRAM line prefetch into a pixel FIFO for the VGA side
// Optional underflow flag/counter enabled by `define FB_SCANOUT_UNDERFLOW_EN.
module fb_scanout_reader #(
  parameter int FB_WIDTH   = gpu_fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT  = gpu_fb_pkg::FB_HEIGHT,
  parameter int FIFO_DEPTH = gpu_fb_pkg::FIFO_DEPTH
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       iFRAME_START,
  input  logic                       iLINE_START,
  input  logic                       iPIX_REQ,
  fb_scanout_reader_if.master        bus,
  output logic [15:0]                oPIX_DATA,
  output logic                       oPIX_VALID,
  output logic                       oUNDERFLOW,
  output logic [7:0]                 oUNDERFLOW_CNT
);
  import gpu_fb_pkg::*;

  localparam int RW    = $clog2(FB_HEIGHT + 1);
  localparam int CW    = $clog2(FB_WIDTH + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fb_state_e            state, state_next;
  logic [RW-1:0]        row, row_next, row_inc;
  logic [CW-1:0]        col, col_next;
  logic                 inflight;
  logic                 line_evt;
  logic                 flush;
  logic                 room;
  logic                 mem_read;
  logic [CNT_W:0]       pending_sum;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic [15:0]          fifo_rdata;
  logic [15:0]          pix_in;
  logic [3:0]           unused_raw_hi;
  logic [FB_ADDR_W-1:0] fetch_addr;

  // Line starts are swallowed once the whole frame has been read
  assign line_evt = iLINE_START & (state != ST_FRAME_DONE);
  assign flush    = iFRAME_START | line_evt;

  assign pending_sum = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign room        = pending_sum < (CNT_W + 1)'(FIFO_DEPTH);
  assign mem_read    = (state == ST_FETCH) & (col < CW'(FB_WIDTH)) & room & ~flush;
  assign fetch_addr  = FB_ADDR_W'(row) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(col);
  assign row_inc     = row + RW'(1);

  assign bus.oMEM_READ = mem_read;
  assign bus.oMEM_ADDR = mem_read ? fetch_addr : '0;
  assign bus.oBUS_BUSY = (state == ST_FETCH) | inflight;

  assign pix_in = {4'h0, bus.iMEM_DATA[PIX_R_MSB:PIX_R_LSB],
                   bus.iMEM_DATA[PIX_G_MSB:PIX_G_LSB],
                   bus.iMEM_DATA[PIX_B_MSB:PIX_B_LSB]};
  assign unused_raw_hi = bus.iMEM_DATA[15:12];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_IDLE;
      row      <= '0;
      col      <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      row      <= row_next;
      col      <= col_next;
      inflight <= mem_read;
    end
  end

  always_comb begin
    state_next = state;
    row_next   = row;
    col_next   = col;
    if (iFRAME_START) begin
      state_next = ST_IDLE;
      row_next   = '0;
      col_next   = '0;
    end else begin
      case (state)
        ST_IDLE, ST_LINE_DONE: begin
          if (iLINE_START) begin
            state_next = ST_FETCH;
            col_next   = '0;
          end
        end
        ST_FETCH: begin
          if (iLINE_START) begin
            row_next   = row_inc;
            col_next   = '0;
            state_next = (row_inc == RW'(FB_HEIGHT)) ? ST_FRAME_DONE : ST_FETCH;
          end else if (mem_read) begin
            col_next = col + CW'(1);
            if (col == CW'(FB_WIDTH - 1)) begin
              row_next   = row_inc;
              state_next = (row_inc == RW'(FB_HEIGHT)) ? ST_FRAME_DONE : ST_LINE_DONE;
            end
          end
        end
        ST_FRAME_DONE: state_next = ST_FRAME_DONE;
        default:       state_next = ST_IDLE;
      endcase
    end
  end

  // Data for a read issued before a flush arrives during the flush and is dropped
  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16),
    .CNT_W (CNT_W)
  ) u_fifo (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .flush  (flush),
    .push   (inflight & ~flush),
    .pop    (iPIX_REQ),
    .wdata  (pix_in),
    .rdata  (fifo_rdata),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

  assign oPIX_VALID = ~fifo_empty;
  assign oPIX_DATA  = fifo_empty ? 16'h0000 : fifo_rdata;

`ifdef FB_SCANOUT_UNDERFLOW_EN
  logic       uf_flag;
  logic [7:0] uf_cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      uf_flag <= 1'b0;
      uf_cnt  <= '0;
    end else if (iFRAME_START) begin
      uf_flag <= 1'b0;
      uf_cnt  <= '0;
    end else if (iPIX_REQ && fifo_empty) begin
      uf_flag <= 1'b1;
      if (uf_cnt != 8'hFF) uf_cnt <= uf_cnt + 8'd1;
    end
  end

  assign oUNDERFLOW     = uf_flag;
  assign oUNDERFLOW_CNT = uf_cnt;
`else
  assign oUNDERFLOW     = 1'b0;
  assign oUNDERFLOW_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb/tb_fb_scanout_reader.sv - randomized self-checking bench for fb_scanout_reader against a line/pixel queue model
module tb_fb_scanout_reader;
  import gpu_fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        pix_req = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        underflow;
  logic [7:0]  uf_cnt;

  fb_scanout_reader_if bus ();

  fb_scanout_reader dut (
    .iCLK           (clk),
    .iRST_N         (rst_n),
    .iFRAME_START   (frame_start),
    .iLINE_START    (line_start),
    .iPIX_REQ       (pix_req),
    .bus            (bus),
    .oPIX_DATA      (pix_data),
    .oPIX_VALID     (pix_valid),
    .oUNDERFLOW     (underflow),
    .oUNDERFLOW_CNT (uf_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: where the reader is in the frame, and the pixels it owes the VGA side
  bit          m_active;
  bit          m_frame_done;
  int          m_row;
  int          m_col;
  logic [15:0] q[$];
  bit          m_pend;
  logic [15:0] m_pend_data;
  int          m_uf;
  bit          m_uf_flag;

  int          reads_seen;
  int          pops_seen;
  bit          last_read;
  logic [17:0] last_addr;

  function automatic logic [15:0] pix_of(input logic [17:0] a);
    return {4'h0, a[11:0]};
  endfunction

  task automatic model_reset();
    m_active = 0; m_frame_done = 0; m_row = 0; m_col = 0;
    q.delete(); m_pend = 0; m_uf = 0; m_uf_flag = 0;
  endtask

  task automatic cyc(input bit fs, input bit ls, input bit pr, input bit rn);
    bit ls_eff, flush, exp_read;
    int exp_addr;
    @(negedge clk);
    frame_start = fs;
    line_start  = ls;
    pix_req     = pr;
    rst_n       = rn;
    bus.iMEM_DATA = last_read ? last_addr[15:0] : 16'($urandom);
    #1;
    if (!rn) begin
      check("rst_mem_read", 32'(bus.oMEM_READ), 0);
      check("rst_mem_addr", 32'(bus.oMEM_ADDR), 0);
      check("rst_bus_busy", 32'(bus.oBUS_BUSY), 0);
      check("rst_pix_valid", 32'(pix_valid), 0);
      check("rst_pix_data", 32'(pix_data), 0);
      check("rst_underflow", 32'(underflow), 0);
      check("rst_uf_cnt", 32'(uf_cnt), 0);
      model_reset();
      last_read = 0;
      return;
    end

    ls_eff   = ls && !m_frame_done;
    flush    = fs || ls_eff;
    exp_read = m_active && (m_col < FB_WIDTH) && !flush && ((q.size() + int'(m_pend)) < FIFO_DEPTH);
    exp_addr = exp_read ? m_row * FB_WIDTH + m_col : 0;

    check("mem_read", 32'(bus.oMEM_READ), 32'(exp_read));
    check("mem_addr", 32'(bus.oMEM_ADDR), 32'(exp_addr));
    check("bus_busy", 32'(bus.oBUS_BUSY), 32'(m_active || m_pend));
    check("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
    check("pix_data", 32'(pix_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
`ifdef FB_SCANOUT_UNDERFLOW_EN
    check("underflow", 32'(underflow), 32'(m_uf_flag));
    check("uf_cnt", 32'(uf_cnt), 32'(m_uf));
`else
    check("underflow", 32'(underflow), 0);
    check("uf_cnt", 32'(uf_cnt), 0);
`endif

    if (bus.oMEM_READ) reads_seen++;
    if (pr && pix_valid) pops_seen++;

    if (fs) begin
      m_uf = 0; m_uf_flag = 0;
    end else if (pr && q.size() == 0) begin
      m_uf_flag = 1;
      m_uf = (m_uf >= 255) ? 255 : m_uf + 1;
    end

    if (flush) begin
      q.delete();
      m_pend = 0;
      if (fs) begin
        m_row = 0; m_col = 0; m_active = 0; m_frame_done = 0;
      end else if (m_active) begin
        m_row++; m_col = 0;
        if (m_row == FB_HEIGHT) begin m_active = 0; m_frame_done = 1; end
      end else begin
        m_active = 1; m_col = 0;
      end
    end else begin
      if (m_pend) check("no_push_full", 32'(q.size() < FIFO_DEPTH), 1);
      if (pr && q.size() != 0) void'(q.pop_front());
      if (m_pend) q.push_back(m_pend_data);
      m_pend = exp_read;
      if (exp_read) begin
        m_pend_data = pix_of(18'(exp_addr));
        m_col++;
        if (m_col == FB_WIDTH) begin
          m_row++; m_active = 0;
          if (m_row == FB_HEIGHT) m_frame_done = 1;
        end
      end
    end
    last_read = bus.oMEM_READ;
    last_addr = bus.oMEM_ADDR;
  endtask

  initial begin
    int guard;
    int r;
    bus.iMEM_DATA = '0;
    last_read = 0;
    last_addr = '0;
    model_reset();

    repeat (3) cyc(0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1);

    // Prefetch stops at FIFO depth with nobody popping
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    reads_seen = 0;
    repeat (30) cyc(0, 0, 0, 1);
    check("prefetch_reads", 32'(reads_seen), 8);
    check("prefetch_valid", 32'(pix_valid), 1);
    check("prefetch_idle_read", 32'(bus.oMEM_READ), 0);

    // Underflow on an empty FIFO, cleared by frame start
    cyc(1, 0, 0, 1);
    repeat (3) cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
`ifdef FB_SCANOUT_UNDERFLOW_EN
    check("uf_flag_after3", 32'(underflow), 1);
    check("uf_cnt_after3", 32'(uf_cnt), 3);
`else
    check("uf_flag_after3", 32'(underflow), 0);
    check("uf_cnt_after3", 32'(uf_cnt), 0);
`endif
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("uf_flag_cleared", 32'(underflow), 0);
    check("uf_cnt_cleared", 32'(uf_cnt), 0);

    // One full line with continuous pixel demand
    cyc(0, 1, 0, 1);
    pops_seen = 0;
    repeat (700) cyc(0, 0, 1, 1);
    check("line_pixels", 32'(pops_seen), 640);
    check("line_done_busy", 32'(bus.oBUS_BUSY), 0);

    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    check("line2_read", 32'(last_read), 1);
    check("line2_first_addr", 32'(last_addr), 640);

    // Walk the rest of the frame with early line starts
    guard = 0;
    while (!m_frame_done && guard < 20000) begin
      cyc(0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1);
      guard++;
    end
    check("frame_walk_bound", 32'(guard < 20000), 1);
    reads_seen = 0;
    cyc(0, 1, 1, 1);
    repeat (20) cyc(0, 0, 1'($urandom_range(0, 1)), 1);
    check("frame_done_reads", 32'(reads_seen), 0);
    check("frame_done_busy", 32'(bus.oBUS_BUSY), 0);

    // Abandon a line mid-fetch at col 100
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    repeat (5) cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 1);
    guard = 0;
    while (m_col < 100 && guard < 500) begin
      cyc(0, 0, 1, 1);
      guard++;
    end
    check("abandon_bound", 32'(guard < 500), 1);
    r = m_row;
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 1);
    check("abandon_next_addr", 32'(last_addr), 32'((r + 1) * FB_WIDTH));

    // Reset pulse in the middle of a fetch
    repeat (20) cyc(0, 0, 1'($urandom_range(0, 1)), 1);
    cyc(0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1);
    check("post_rst_valid", 32'(pix_valid), 0);

    // Mixed random traffic
    cyc(1, 0, 0, 1);
    repeat (4000) begin
      r = $urandom_range(0, 299);
      cyc((r == 0), (r > 0 && r < 9), ($urandom_range(0, 9) < 7), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
